// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg
//   Shared types and constants for the UART transmit frame sequencer.
//   - tx_state_t : frame sequencer state encoding (3 bits)
//   - PAR_EVEN / PAR_ODD : values of the PAR_TYP input
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if
//   Host-side byte handshake of the UART transmit path.
//   master (host)      : drives P_DATA_IN, DATA_VALID, PAR_EN, PAR_TYP; reads READY
//   slave  (sequencer) : reads P_DATA_IN, DATA_VALID, PAR_EN, PAR_TYP; drives READY
//   A byte is transferred on a rising edge where DATA_VALID & READY.
interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA_IN;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  READY;

  modport master (
    output P_DATA_IN, DATA_VALID, PAR_EN, PAR_TYP,
    input  READY
  );

  modport slave (
    input  P_DATA_IN, DATA_VALID, PAR_EN, PAR_TYP,
    output READY
  );
endinterface

// File: rtl/uart_tx_parity_calc.sv
// uart_tx_parity_calc
//   Combinational parity bit for one payload word.
//   data    in  DATA_WIDTH  payload
//   par_typ in  1           PAR_EVEN / PAR_ODD
//   par_bit out 1           bit that makes the total count of ones even / odd
module uart_tx_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  assign par_bit = (par_typ == PAR_ODD) ? ~^data : ^data;

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl
//   Frame sequencer for the UART transmit path. Accepts a byte from the host,
//   latches it for the serializer, enables the serializer and builds the line
//   as start bit, serializer data, optional parity bit, stop bit.
//   Optional feature macro: UART_TX_PARITY_EN (builds the PARITY state and
//   parity register; without it PAR_EN/PAR_TYP are ignored).
//
//   CLK       in   bit clock, one clock per line bit
//   RST       in   asynchronous active-low reset
//   host      if   slave side: P_DATA_IN, DATA_VALID, PAR_EN, PAR_TYP, READY
//   Ser_Data  in   serial bit from serializer
//   Ser_Done  in   serializer last-bit flag
//   P_DATA    out  latched payload to serializer
//   Ser_En    out  serializer enable
//   TX_OUT    out  UART line
//   BUSY      out  frame in progress
//   SER_ERR   out  one-cycle pulse when the serializer overruns
//
//   state  | meaning
//   IDLE   | line high, waiting for a byte
//   START  | start bit (0) on line, serializer loading
//   DATA   | serializer bits on line, LSB first
//   PARITY | parity bit on line
//   STOP   | stop bit (1) on line; may accept the next byte
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  uart_tx_ctrl_if.slave         host,
  input  logic                  Ser_Data,
  input  logic                  Ser_Done,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Ser_En,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  SER_ERR
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  tx_state_t        state;
  logic [CNT_W-1:0] bit_cnt;
  logic             accept;

  assign host.READY = (state == IDLE) || (state == STOP);
  assign accept     = host.DATA_VALID && host.READY;

`ifdef UART_TX_PARITY_EN
  // PAR_TYP only matters through parity_q, which is fixed at accept time.
  logic par_en_q;
  logic parity_q;
  logic parity_next;

  uart_tx_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity_calc (
    .data    (host.P_DATA_IN),
    .par_typ (host.PAR_TYP),
    .par_bit (parity_next)
  );
`else
  logic unused_par_cfg;
  assign unused_par_cfg = host.PAR_EN ^ host.PAR_TYP;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      P_DATA   <= '0;
      bit_cnt  <= '0;
      SER_ERR  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q <= 1'b0;
      parity_q <= 1'b0;
`endif
    end else begin
      SER_ERR <= 1'b0;
      if (accept) begin
        P_DATA   <= host.P_DATA_IN;
`ifdef UART_TX_PARITY_EN
        par_en_q <= host.PAR_EN;
        parity_q <= parity_next;
`endif
      end
      case (state)
        IDLE:   if (accept) state <= START;
        START: begin
          bit_cnt <= '0;
          state   <= DATA;
        end
        DATA: begin
          if (Ser_Done) begin
`ifdef UART_TX_PARITY_EN
            state <= par_en_q ? PARITY : STOP;
`else
            state <= STOP;
`endif
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            // Last expected bit went by without Ser_Done: serializer overran.
            if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
              SER_ERR <= 1'b1;
              state   <= STOP;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: state <= STOP;
`endif
        STOP:    state <= accept ? START : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Line mux follows state directly so an async reset forces the line high.
  always_comb begin
    TX_OUT = 1'b1;
    case (state)
      START:  TX_OUT = 1'b0;
      DATA:   TX_OUT = Ser_Data;
`ifdef UART_TX_PARITY_EN
      PARITY: TX_OUT = parity_q;
`endif
      default: TX_OUT = 1'b1;
    endcase
  end

  assign Ser_En = (state == START) || ((state == DATA) && !Ser_Done);
  assign BUSY   = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl
//   Bench for uart_tx_ctrl with a behavioural serializer attached. Expected
//   line, enable, ready and error sequences are built per frame from the
//   UART frame rules and compared every cycle on the falling edge.
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  logic       CLK;
  logic       RST;
  logic       Ser_Data;
  logic       Ser_Done;
  logic [7:0] P_DATA;
  logic       Ser_En;
  logic       TX_OUT;
  logic       BUSY;
  logic       SER_ERR;

  int tests_run;
  int tests_failed;

  uart_tx_ctrl_if #(.DATA_WIDTH(8)) host_if ();

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .host     (host_if),
    .Ser_Data (Ser_Data),
    .Ser_Done (Ser_Done),
    .P_DATA   (P_DATA),
    .Ser_En   (Ser_En),
    .TX_OUT   (TX_OUT),
    .BUSY     (BUSY),
    .SER_ERR  (SER_ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Serializer model: loads P_DATA on a rising Ser_En, then shifts out
  // 8 bits LSB first, flagging the last one (unless no_done is set).
  bit         no_done;
  logic       ser_active;
  logic       ser_en_d;
  logic [2:0] ser_idx;
  logic [7:0] ser_shreg;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ser_active <= 1'b0;
      ser_en_d   <= 1'b0;
      ser_idx    <= 3'd0;
      ser_shreg  <= 8'h00;
    end else begin
      ser_en_d <= Ser_En;
      if (Ser_En && !ser_en_d) begin
        ser_active <= 1'b1;
        ser_idx    <= 3'd0;
        ser_shreg  <= P_DATA;
      end else if (ser_active) begin
        if (ser_idx == 3'd7) ser_active <= 1'b0;
        else                 ser_idx <= ser_idx + 3'd1;
      end
    end
  end

  assign Ser_Data = ser_shreg[ser_idx];
  assign Ser_Done = ser_active && (ser_idx == 3'd7) && !no_done;

  // Expected per-cycle observations for the frames in flight.
  bit         e_tx[$];
  bit         e_en[$];
  bit         e_rdy[$];
  bit         e_err[$];
  logic [7:0] e_pd[$];

  task automatic push_cycle(input bit tx, input bit en, input bit rdy,
                            input bit err, input logic [7:0] pd);
    e_tx.push_back(tx);
    e_en.push_back(en);
    e_rdy.push_back(rdy);
    e_err.push_back(err);
    e_pd.push_back(pd);
  endtask

  task automatic push_frame(input logic [7:0] d, input logic pen,
                            input logic ptyp, input bit fault);
    bit has_par;
    bit par;
    has_par = PAR_BUILT && pen && !fault;
    par     = bit'(($countones(d) % 2) != 0) ^ ptyp;
    push_cycle(1'b0, 1'b1, 1'b0, 1'b0, d);
    for (int k = 0; k < 8; k++)
      push_cycle(d[k], fault ? 1'b1 : (k < 7), 1'b0, 1'b0, d);
    if (has_par) push_cycle(par, 1'b0, 1'b0, 1'b0, d);
    push_cycle(1'b1, 1'b0, 1'b1, fault, d);
  endtask

  // Called on a falling edge with the DUT idle. n = 1 or 2 frames; for two
  // frames DATA_VALID is held so the second byte is taken in the first STOP.
  task automatic run_frames(input int n, input logic [7:0] d0, input logic [7:0] d1,
                            input logic pen, input logic ptyp, input bit fault,
                            input string name);
    int len0;
    e_tx.delete(); e_en.delete(); e_rdy.delete(); e_err.delete(); e_pd.delete();
    push_frame(d0, pen, ptyp, fault);
    len0 = e_tx.size();
    if (n == 2) push_frame(d1, pen, ptyp, fault);
    no_done = fault;

    host_if.P_DATA_IN  = d0;
    host_if.DATA_VALID = 1'b1;
    host_if.PAR_EN     = pen;
    host_if.PAR_TYP    = ptyp;
    tests_run++;
    if (host_if.READY !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s ready_before_accept: READY=%b expected 1", name, host_if.READY);
    end
    @(negedge CLK);
    if (n == 2) host_if.P_DATA_IN = d1;
    else begin
      host_if.DATA_VALID = 1'b0;
      host_if.P_DATA_IN  = 8'($urandom);
      host_if.PAR_EN     = 1'($urandom);
      host_if.PAR_TYP    = 1'($urandom);
    end

    for (int i = 0; i < e_tx.size(); i++) begin
      tests_run++;
      if (TX_OUT !== e_tx[i] || Ser_En !== e_en[i] || host_if.READY !== e_rdy[i] ||
          SER_ERR !== e_err[i] || P_DATA !== e_pd[i] || BUSY !== 1'b1) begin
        tests_failed++;
        $display("FAIL %s cycle %0d: got tx=%b en=%b rdy=%b err=%b pd=%h busy=%b, expected tx=%b en=%b rdy=%b err=%b pd=%h busy=1",
                 name, i, TX_OUT, Ser_En, host_if.READY, SER_ERR, P_DATA, BUSY,
                 e_tx[i], e_en[i], e_rdy[i], e_err[i], e_pd[i]);
      end
      if (n == 2 && i == len0) begin
        host_if.DATA_VALID = 1'b0;
        host_if.P_DATA_IN  = 8'($urandom);
        host_if.PAR_EN     = 1'($urandom);
        host_if.PAR_TYP    = 1'($urandom);
      end
      @(negedge CLK);
    end

    tests_run++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0 || host_if.READY !== 1'b1 ||
        Ser_En !== 1'b0 || SER_ERR !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s idle_after: got tx=%b busy=%b rdy=%b en=%b err=%b, expected tx=1 busy=0 rdy=1 en=0 err=0",
               name, TX_OUT, BUSY, host_if.READY, Ser_En, SER_ERR);
    end
    no_done = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    #1;
    tests_run++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0 || host_if.READY !== 1'b1 ||
        Ser_En !== 1'b0 || SER_ERR !== 1'b0 || P_DATA !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_values: tx=%b busy=%b rdy=%b en=%b err=%b pd=%h, expected 1 0 1 0 0 00",
               TX_OUT, BUSY, host_if.READY, Ser_En, SER_ERR, P_DATA);
    end
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      tests_run++;
      if (TX_OUT !== 1'b1 || BUSY !== 1'b0 || host_if.READY !== 1'b1 || Ser_En !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_idle cycle %0d: tx=%b busy=%b rdy=%b en=%b, expected 1 0 1 0",
                 i, TX_OUT, BUSY, host_if.READY, Ser_En);
      end
    end
  endtask

  task automatic test_even_parity();
    run_frames(1, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b0, "frame_a5_even");
  endtask

  task automatic test_odd_parity();
    run_frames(1, 8'h07, 8'h00, 1'b1, 1'b1, 1'b0, "frame_07_odd");
    run_frames(1, 8'h03, 8'h00, 1'b1, 1'b1, 1'b0, "frame_03_odd");
  endtask

  task automatic test_back_to_back();
    run_frames(2, 8'h55, 8'hFF, 1'b1, 1'b0, 1'b0, "b2b_55_ff_par");
    run_frames(2, 8'h81, 8'h7E, 1'b0, 1'b0, 1'b0, "b2b_81_7e_nopar");
  endtask

  task automatic test_ser_overrun();
    run_frames(1, 8'hC3, 8'h00, 1'b1, 1'b0, 1'b1, "overrun_c3");
    repeat (2) @(negedge CLK);
    run_frames(1, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, "after_overrun_5a");
  endtask

  task automatic test_reset_mid_frame();
    host_if.P_DATA_IN  = 8'h96;
    host_if.DATA_VALID = 1'b1;
    host_if.PAR_EN     = 1'b1;
    host_if.PAR_TYP    = 1'b0;
    @(negedge CLK);
    host_if.DATA_VALID = 1'b0;
    repeat (4) @(negedge CLK);
    tests_run++;
    if (BUSY !== 1'b1 || Ser_En !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_frame_busy: busy=%b en=%b, expected 1 1", BUSY, Ser_En);
    end
    #2;
    RST = 1'b0;
    #1;
    tests_run++;
    if (TX_OUT !== 1'b1 || Ser_En !== 1'b0 || BUSY !== 1'b0 || host_if.READY !== 1'b1 ||
        P_DATA !== 8'h00 || SER_ERR !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: tx=%b en=%b busy=%b rdy=%b pd=%h err=%b, expected 1 0 0 1 00 0",
               TX_OUT, Ser_En, BUSY, host_if.READY, P_DATA, SER_ERR);
    end
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    run_frames(1, 8'h3C, 8'h00, 1'b1, 1'b0, 1'b0, "post_reset_3c");
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      int n;
      int gap;
      n   = int'($urandom_range(1, 2));
      gap = int'($urandom_range(0, 3));
      run_frames(n, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0, "random");
      repeat (gap) @(negedge CLK);
    end
  endtask

  initial begin
    tests_run          = 0;
    tests_failed       = 0;
    no_done            = 1'b0;
    RST                = 1'b0;
    host_if.P_DATA_IN  = 8'h00;
    host_if.DATA_VALID = 1'b0;
    host_if.PAR_EN     = 1'b0;
    host_if.PAR_TYP    = 1'b0;

    test_reset();
    test_even_parity();
    test_odd_parity();
    test_back_to_back();
    test_ser_overrun();
    test_reset_mid_frame();
    test_random();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Frame sequencer for the UART transmit path. It accepts a parallel byte through a valid/ready handshake, latches it, and drives the serializer's enable. It also builds the line output by multiplexing the start bit, serializer data, optional parity bit and stop bit. It sits between the TX host interface and the shared serializer instance. It is the only block that drives the serializer's P_DATA and Ser_En.

## Interface
- DATA_WIDTH, 8, payload bits per frame (must match the serializer).
- CLK  in  1  bit clock; one clock per line bit.
- RST  in  1  asynchronous, active-low reset.
- P_DATA_IN  in  DATA_WIDTH  host payload.
- DATA_VALID  in  1  host offers P_DATA_IN.
- PAR_EN  in  1  parity bit enabled for this frame.
- PAR_TYP  in  1  0 = even, 1 = odd.
- Ser_Data  in  1  serial bit from serializer.
- Ser_Done  in  1  serializer last-bit flag.
- READY  out  1  handshake ready.
- P_DATA  out  DATA_WIDTH  latched payload to serializer.
- Ser_En  out  1  serializer enable.
- TX_OUT  out  1  UART line.
- BUSY  out  1  frame in progress.
- SER_ERR  out  1  one-cycle pulse when the serializer overruns.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Accept: DATA_VALID & READY sampled at a rising edge. READY = (state==IDLE) | (state==STOP).
  - On accept, latch P_DATA_IN into P_DATA.
  - On accept, latch PAR_EN and PAR_TYP into frame registers.
  - On accept, compute the parity register: even = ^P_DATA_IN, odd = ~^P_DATA_IN.
- IDLE: on accept go to START, else stay.
- START: always go to DATA. Clear bit_cnt.
- DATA: on Ser_Done, go to PARITY if par_en_q, else STOP.
  - Otherwise increment bit_cnt.
  - If bit_cnt reaches DATA_WIDTH without Ser_Done, pulse SER_ERR for one cycle and go to STOP.
- PARITY: always go to STOP.
- STOP: on accept go to START (back-to-back frames, no idle gap), else go to IDLE.
- Ser_En = (state==START) | (state==DATA & ~Ser_Done).
- TX_OUT, combinational on state:
  - IDLE: 1.
  - START: 0.
  - DATA: Ser_Data.
  - PARITY: parity register.
  - STOP: 1.
- BUSY = state != IDLE.
- P_DATA is stable from accept until the next accept.
- PAR_EN/PAR_TYP changes mid-frame have no effect.
- DATA_VALID while not READY is ignored. The host holds it until accepted.

## Timing
- Reset values:
  - state IDLE.
  - TX_OUT 1.
  - Ser_En 0.
  - BUSY 0.
  - READY 1.
  - SER_ERR 0.
  - P_DATA 0.
  - parity register 0.
  - bit_cnt 0.
- Reset mid-frame: the line returns to 1 immediately (asynchronously). No partial stop bit is emitted.
- Accept at edge N: TX_OUT=0 during cycle N+1.
- Data bits, LSB first: cycles N+2 .. N+1+DATA_WIDTH.
- Parity bit: cycle N+2+DATA_WIDTH.
- Stop bit follows.
- Frame length: DATA_WIDTH+2 cycles without parity, DATA_WIDTH+3 with parity.
- Serializer contract: Ser_En sampled at the START edge produces bit0 in the first DATA cycle. Ser_Done is high in the same cycle as the last bit.
- Ser_En deasserts in the last DATA cycle.
- Back-to-back: accept in STOP gives a new START on the next cycle. Throughput is one frame per DATA_WIDTH+2/+3 cycles.

## Configuration
- UART_TX_PARITY_EN defined:
  - Parity as described.
- UART_TX_PARITY_EN undefined:
  - PARITY state and parity register are not built.
  - PAR_EN and PAR_TYP ports remain but are ignored.
  - DATA always goes to STOP.
  - Frame is always DATA_WIDTH+2 cycles.

## Structure
- Shared package uart_tx_pkg holds:
  - State encodings: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit.
  - Parity type constants: PAR_EVEN=0, PAR_ODD=1.
- One sub-module: uart_tx_parity_calc (combinational parity of DATA_WIDTH bits plus type). It is instantiated only under UART_TX_PARITY_EN.
- The serializer is instantiated by the parent uart_tx top, not inside this block.

## Test plan
- Reset, no stimulus: TX_OUT=1, BUSY=0, READY=1, Ser_En=0 for 20 cycles.
- 0xA5, PAR_EN=1, PAR_TYP=0, with serializer attached:
  - TX_OUT sequence is 0,1,0,1,0,0,1,0,1,0,1 (parity 0), then idle.
  - BUSY is high for 11 cycles.
- 0x07, odd parity: parity bit = 0. Then 0x03, odd parity: parity bit = 1.
- Two frames 0x55 and 0xFF with DATA_VALID held:
  - The second START immediately follows the first STOP.
  - No idle cycle between frames.
- Serializer model that never asserts Ser_Done: SER_ERR pulses once after 8 DATA cycles, STOP is emitted, and the block returns to IDLE.
- RST asserted mid-DATA: TX_OUT=1 and Ser_En=0 immediately. After release, a fresh 0x3C frame transmits correctly.
